// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: dark patterns, glyph ROM, digit index type.
package fnd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] COM_OFF   = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Active-low {g,f,e,d,c,b,a} for hex 0..F; element 15 is listed first.
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/decoder_7seg.sv
// Combinational hex nibble to active-low 7-segment glyph {g..a}.
module decoder_7seg
    import fnd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH[i_nib];

endmodule

// File: rtl/fnd_4digit_cntr.sv
// Four-digit common-anode FND scanner with a per-frame snapshot and a dark guard cycle per slot.
// Optional leading-zero blanking of digits 3..1 when FND_BLANK_EN is defined.
module fnd_4digit_cntr
    import fnd_pkg::*;
#(
    parameter int         CLK_FREQ = 100_000_000,
    parameter int         SCAN_HZ  = 1000,
    parameter logic [3:0] DP_MASK  = 4'b0100
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [15:0] value,
    output logic [7:0]  seg_7,
    output logic [3:0]  com
);

    localparam int DIV   = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_chk
        $error("fnd_4digit_cntr: CLK_FREQ/SCAN_HZ must be at least 2");
    end

    logic [CNT_W-1:0] r_cnt;
    digit_idx_t       r_idx;
    logic [15:0]      r_snap;
    logic [3:0]       r_com;
    logic [7:0]       r_seg;

    logic             w_tick;
    logic             w_guard;
    logic [3:0]       w_nib;
    logic [6:0]       w_glyph;
    logic             w_blank;

    assign w_tick  = (r_cnt == CNT_W'(DIV - 1));
    assign w_guard = (r_cnt == '0);
    assign w_nib   = r_snap[{r_idx, 2'b00} +: 4];

    decoder_7seg u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

`ifdef FND_BLANK_EN
    // A digit goes dark while it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = (r_snap[15:4]  == 12'h000);
            2'd2:    w_blank = (r_snap[15:8]  == 8'h00);
            2'd3:    w_blank = (r_snap[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_snap <= 16'h0000;
            r_com  <= COM_OFF;
            r_seg  <= SEG_BLANK;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick)
                r_idx <= r_idx + 1'b1;
            // Snapshot once per frame so all four digits come from the same value.
            if (w_guard && (r_idx == 2'd0))
                r_snap <= value;
            if (w_guard) begin
                r_com <= COM_OFF;
                r_seg <= SEG_BLANK;
            end else begin
                r_com <= ~(4'b0001 << r_idx);
                r_seg <= w_blank ? SEG_BLANK : {~DP_MASK[r_idx], w_glyph};
            end
        end
    end

    assign com   = r_com;
    assign seg_7 = r_seg;

`ifndef SYNTHESIS
    // Outputs lag the slot state by one register, so the guard shows up while cnt == 1.
    always @(posedge clk) begin
        if (!reset_p) begin
            assert ($onehot0(~com)) else $error("com has more than one digit enabled");
            if (r_cnt == CNT_W'(1))
                assert (com == COM_OFF) else $error("com not dark during guard");
        end
    end
`endif

endmodule

// File: tb/tb_fnd_4digit_cntr.sv
// Scoreboard bench for fnd_4digit_cntr with DIV=4; honours FND_BLANK_EN like the design.
module tb_fnd_4digit_cntr;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [7:0]  seg_7;
    logic [3:0]  com;

    int checks = 0;
    int errors = 0;

    logic [11:0] sb_q[$];

    localparam logic [6:0] TB_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    fnd_4digit_cntr #(
        .CLK_FREQ (8),
        .SCAN_HZ  (2),
        .DP_MASK  (4'b0100)
    ) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .value   (value),
        .seg_7   (seg_7),
        .com     (com)
    );

    always #5 clk = ~clk;

    // Expected {com, seg_7} for one 16-clock frame showing v.
    task automatic push_frame(input logic [15:0] v);
        logic [3:0] nib;
        logic       blank;
        for (int d = 0; d < 4; d++) begin
            nib   = 4'((v >> (4 * d)) & 16'hF);
            blank = 1'b0;
`ifdef FND_BLANK_EN
            if (d > 0 && (v >> (4 * d)) == 16'h0) blank = 1'b1;
`endif
            sb_q.push_back({4'b1111, 8'hFF});
            for (int c = 1; c < 4; c++) begin
                if (blank)
                    sb_q.push_back({~(4'b0001 << d), 8'hFF});
                else
                    sb_q.push_back({~(4'b0001 << d), (d == 2) ? 1'b0 : 1'b1, TB_GLYPH[nib]});
            end
        end
    endtask

    task automatic test_reset;
        reset_p = 1'b1;
        value   = 16'h1234;
        repeat (3) @(negedge clk);
        checks++;
        if (com !== 4'b1111) begin
            errors++;
            $display("FAIL reset_com got %b want 1111", com);
        end
        checks++;
        if (seg_7 !== 8'hFF) begin
            errors++;
            $display("FAIL reset_seg got %h want ff", seg_7);
        end
        reset_p = 1'b0;
    endtask

    task automatic test_basic;
        logic [11:0] e;
        push_frame(16'h1234);
        push_frame(16'h1234);
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({com, seg_7} !== e) begin
                errors++;
                $display("FAIL basic_1234 got com=%b seg=%h want com=%b seg=%h", com, seg_7, e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_midframe_change;
        logic [11:0] e;
        push_frame(16'h1234);
        push_frame(16'h5678);
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (n == 9) value = 16'h5678;
            e = sb_q.pop_front();
            checks++;
            if ({com, seg_7} !== e) begin
                errors++;
                $display("FAIL midframe n=%0d got com=%b seg=%h want com=%b seg=%h", n, com, seg_7, e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_hex;
        logic [11:0] e;
        value = 16'hABCF;
        push_frame(16'hABCF);
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({com, seg_7} !== e) begin
                errors++;
                $display("FAIL hex_abcf got com=%b seg=%h want com=%b seg=%h", com, seg_7, e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_blank;
        logic [11:0] e;
        push_frame(16'h0000);
        push_frame(16'h0042);
        push_frame(16'h0302);
        for (int n = 0; n < 48; n++) begin
            if (n == 0)  value = 16'h0000;
            if (n == 16) value = 16'h0042;
            if (n == 32) value = 16'h0302;
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({com, seg_7} !== e) begin
                errors++;
                $display("FAIL blank n=%0d got com=%b seg=%h want com=%b seg=%h", n, com, seg_7, e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [11:0] e;
        value = 16'h9876;
        // Six samples in: digit 1 is in its drive phase.
        repeat (6) @(negedge clk);
        checks++;
        if (com !== 4'b1101) begin
            errors++;
            $display("FAIL pre_reset_com got %b want 1101", com);
        end
        reset_p = 1'b1;
        #1;
        checks++;
        if (com !== 4'b1111 || seg_7 !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset got com=%b seg=%h want com=1111 seg=ff", com, seg_7);
        end
        @(negedge clk);
        value   = 16'h4567;
        reset_p = 1'b0;
        push_frame(16'h4567);
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({com, seg_7} !== e) begin
                errors++;
                $display("FAIL after_reset got com=%b seg=%h want com=%b seg=%h", com, seg_7, e[11:8], e[7:0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_midframe_change;
        test_hex;
        test_blank;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
